// File: rtl/screen_pkg.sv
// Shared types and sizing helpers for the character screen sequencer.
package screen_pkg;

  typedef enum logic [1:0] {
    OP_PUTC      = 2'd0,
    OP_NEWLINE   = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_BACKSPACE = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_SCROLL = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  function automatic int nloc(input int cols, input int rows);
    return cols * rows;
  endfunction

  function automatic int addr_w(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

endpackage

// File: rtl/screen_cursor.sv
// Cursor position plus its linear screen address, kept in step without a multiplier.
module screen_cursor
  import screen_pkg::*;
#(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS),
  parameter int AW   = addr_w(COLS, ROWS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic          retreat,
  input  logic          newline,
  input  logic          home,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          wrap,
  output logic          at_bottom
);

  localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

  assign wrap      = (x == XMAX);
  assign at_bottom = (y == YMAX);

  always_ff @(posedge clock) begin
    if (reset || home) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      if (wrap) begin
        x <= '0;
        if (!at_bottom) begin
          y    <= y + 1'b1;
          addr <= addr + 1'b1;
        end else begin
          // bottom row stays; the scroll moves content up under the cursor
          addr <= addr - AW'(COLS - 1);
        end
      end else begin
        x    <= x + 1'b1;
        addr <= addr + 1'b1;
      end
    end else if (newline) begin
      x <= '0;
      if (!at_bottom) begin
        y    <= y + 1'b1;
        addr <= addr - AW'(x) + AW'(COLS);
      end else begin
        addr <= addr - AW'(x);
      end
    end else if (retreat) begin
      if (x != '0) begin
        x    <= x - 1'b1;
        addr <= addr - 1'b1;
      end else if (y != '0) begin
        x    <= XMAX;
        y    <= y - 1'b1;
        addr <= addr - 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_ctrl.sv
// Command sequencer for the VGA character screen: cursor writes, clear and scroll sweeps.
module screen_ctrl
  import screen_pkg::*;
#(
  parameter int               COLS  = 40,
  parameter int               ROWS  = 30,
  parameter int               Dbits = 4,
  parameter logic [Dbits-1:0] BLANK = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [Dbits-1:0]                 cmd_char,
  output logic                             mem_wr,
  output logic [addr_w(COLS, ROWS)-1:0]    mem_waddr,
  output logic [Dbits-1:0]                 mem_wdata,
  output logic [addr_w(COLS, ROWS)-1:0]    mem_raddr,
  input  logic [Dbits-1:0]                 mem_rdata,
  output logic [$clog2(COLS)-1:0]          cursor_x,
  output logic [$clog2(ROWS)-1:0]          cursor_y,
  output logic                             busy
);

  localparam int AW   = addr_w(COLS, ROWS);
  localparam int NLOC = nloc(COLS, ROWS);
  localparam logic [AW-1:0] P_LAST  = AW'(NLOC - 1);
  localparam logic [AW-1:0] SRC_END = AW'(NLOC - COLS);

  state_t            state, state_n;
  logic [AW-1:0]     p;
  logic [AW-1:0]     cur_addr;
  logic [Dbits-1:0]  wchar;
  logic              wr_adv;
  logic              accept, advance, wrap, at_bottom, p_last;
  cmd_op_t           op;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == S_SCROLL) || (state == S_CLEAR);
  assign p_last    = (p == P_LAST);

  screen_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance),
    .retreat   (accept && op == OP_BACKSPACE),
    .newline   (accept && op == OP_NEWLINE),
    .home      (accept && op == OP_CLEAR),
    .x         (cursor_x),
    .y         (cursor_y),
    .addr      (cur_addr),
    .wrap      (wrap),
    .at_bottom (at_bottom)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      p      <= '0;
      wchar  <= '0;
      wr_adv <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        wchar  <= (op == OP_PUTC) ? cmd_char : BLANK;
        wr_adv <= (op == OP_PUTC);
      end
      if (busy)
        p <= p_last ? '0 : p + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    mem_wr    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_PUTC, OP_BACKSPACE: state_n = S_WRITE;
            OP_CLEAR:              state_n = S_CLEAR;
            OP_NEWLINE:            state_n = at_bottom ? S_SCROLL : S_IDLE;
            default:               state_n = S_IDLE;
          endcase
        end
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        mem_waddr = cur_addr;
        mem_wdata = wchar;
        advance   = wr_adv;
        state_n   = (wr_adv && wrap && at_bottom) ? S_SCROLL : S_IDLE;
      end
      S_SCROLL: begin
        // ascending sweep reads p+COLS before that cell is itself overwritten
        mem_wr    = 1'b1;
        mem_waddr = p;
        if (p < SRC_END) begin
          mem_raddr = p + AW'(COLS);
          mem_wdata = mem_rdata;
        end else begin
          mem_wdata = BLANK;
        end
        if (p_last) state_n = S_IDLE;
      end
      S_CLEAR: begin
        mem_wr    = 1'b1;
        mem_waddr = p;
        mem_wdata = BLANK;
        if (p_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/screen_ctrl.md
Name: screen_ctrl

Overview:
Sequencer for the dual-read/single-write VGA character screen memory. It accepts single-character terminal commands from a CPU or keyboard front end and maintains a cursor. It turns each command into screen-memory writes, including multi-cycle clear and scroll-up sweeps. It owns the memory write port and read port 2; read port 1 stays with the VGA display scanner.

Parameters:
COLS, 40, characters per row
ROWS, 30, rows per screen; Nloc = COLS*ROWS (default 1200)
Dbits, 4, character code width, equal to the screen memory's Dbits
BLANK, 0, character code written by clear, scroll fill and backspace

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  0=PUTC, 1=NEWLINE, 2=CLEAR, 3=BACKSPACE
cmd_char  in  Dbits  character for PUTC; ignored for other ops
mem_wr  out  1  to screen memory wr
mem_waddr  out  $clog2(Nloc)  to WriteAddr
mem_wdata  out  Dbits  to WriteData
mem_raddr  out  $clog2(Nloc)  to ReadAddr2
mem_rdata  in  Dbits  from ReadData2 (combinational read)
cursor_x  out  $clog2(COLS)  cursor column
cursor_y  out  $clog2(ROWS)  cursor row
busy  out  1  clear or scroll sweep in progress

Behaviour:
- One clock, single edge. Reset is synchronous and active-high.
- Reset values: state=IDLE, cmd_ready=1, mem_wr=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, cursor=(0,0), busy=0.
- Reset does not touch memory contents. Reset asserted mid-sweep aborts the sweep and leaves memory partially updated.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. The source holds cmd_op/cmd_char stable until accepted.
- Cursor linear address: A = cursor_y*COLS + cursor_x. It is kept as an incrementally updated register, with no multiplier.
- States: IDLE, WRITE, SCROLL, CLEAR.
- PUTC accepted (edge N), then state WRITE in cycle N+1:
  - mem_wr=1, mem_waddr=A(old), mem_wdata=cmd_char.
  - At edge N+1 the cursor advances x+1.
  - If x==COLS-1: x=0 and y+1.
  - If y was already ROWS-1: y stays ROWS-1 and the next state is SCROLL; otherwise IDLE.
- NEWLINE accepted: no write. Cursor x=0.
  - If y<ROWS-1: y+1, stay IDLE, next command accepted the following cycle.
  - Else: y stays ROWS-1, go to SCROLL.
- BACKSPACE accepted: move the cursor back one cell, then a WRITE cycle puts BLANK at the new position.
  - At x=0, y>0: move to (COLS-1, y-1).
  - At (0,0): cursor unchanged, BLANK written at address 0.
- CLEAR accepted: CLEAR state for exactly Nloc cycles.
  - mem_wr=1, mem_waddr=0..Nloc-1 ascending, mem_wdata=BLANK, busy=1.
  - Cursor set to (0,0) at acceptance.
- SCROLL: exactly Nloc cycles with busy=1, pointer p=0..Nloc-1.
  - While p<Nloc-COLS: mem_raddr=p+COLS, mem_waddr=p, mem_wdata=mem_rdata (combinational pass-through), mem_wr=1.
  - While p>=Nloc-COLS: mem_wdata=BLANK, mem_wr=1.
  - Ascending order guarantees every source cell is read before it is overwritten.
- Sweep exit: after the last sweep cycle, mem_wr=0, busy=0, cmd_ready=1 in the next cycle.
- mem_wr is never high in IDLE. Exactly one write occurs per WRITE cycle.
- Address width: all address arithmetic is $clog2(Nloc) bits. Counters never exceed Nloc-1.

Decomposition:
- Package screen_pkg: typedef enum cmd_op_t (PUTC, NEWLINE, CLEAR, BACKSPACE); typedef enum state_t (IDLE, WRITE, SCROLL, CLEAR); localparam helpers for Nloc and address width.
- One sub-module, screen_cursor:
  - Holds x, y and linear address.
  - Inputs: advance, retreat, newline, home.
  - Outputs: wrap and at_bottom flags.
  - All cursor wrap logic lives here.

Test Plan:
- Reset, then PUTC 'A'(0xA) → single cycle mem_wr=1, waddr=0, wdata=0xA; cursor (1,0); cmd_ready low for 1 cycle only.
- Cursor at (39,5), PUTC 0x3 → write at addr 239; cursor (0,6); state back to IDLE.
- Cursor at (39,29), PUTC 0x7 → write at addr 1199, then busy=1 for exactly 1200 cycles; old row 1 data appears in row 0; row 29 all BLANK; cursor (0,29).
- CLEAR from (12,7) → 1200 consecutive writes of BLANK, addresses 0..1199; cursor (0,0); cmd_ready returns the cycle after address 1199.
- BACKSPACE at (0,3) → cursor (39,2), BLANK written at addr 119; BACKSPACE at (0,0) → cursor stays (0,0), BLANK at addr 0.
- Reset asserted at cycle 500 of a SCROLL → next cycle mem_wr=0, busy=0, cursor (0,0), cmd_ready=1; cmd_valid held during busy is not accepted until ready.
